// File: rtl/gearbox_packing_tlast.sv
`timescale 1ns/1ps
// AXI-Stream byte packer: drops tkeep=0 lanes and repacks surviving bytes MSB-lane first
// into dense N_OUT-byte words, flushing a partial final word on in_tlast.
module gearbox_packing_tlast #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 10,
    localparam int BUF  = N_IN + N_OUT,
    localparam int CW   = $clog2(BUF + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [N_IN*8-1:0]    in_tdata,
    input  logic [N_IN-1:0]      in_tkeep,
    input  logic                 in_tlast,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    output logic [N_OUT*8-1:0]   out_tdata,
    output logic [N_OUT-1:0]     out_tkeep,
    output logic                 out_tlast,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic [CW-1:0]        fill
);

    typedef enum logic {PACK = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [CW-1:0] LIMIT  = CW'(BUF - N_IN);
    localparam logic [CW-1:0] NOUT_C = CW'(N_OUT);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BUF*8-1:0]   data_q, data_d;

    logic               flush_pending;
    logic               accept;
    logic               emit;
    logic [CW-1:0]      take;

    assign flush_pending = (state_q == FLUSH);
    // Reset gating keeps in_tready low while aresetn is asserted.
    assign in_tready     = aresetn && !flush_pending && (cnt_q <= LIMIT);
    assign out_tvalid    = (cnt_q >= NOUT_C) || flush_pending;
    assign out_tlast     = flush_pending && (cnt_q <= NOUT_C);
    assign take          = (cnt_q >= NOUT_C) ? NOUT_C : cnt_q;
    assign fill          = cnt_q;
    assign accept        = in_tvalid && in_tready;
    assign emit          = out_tvalid && out_tready;

    // Buffer byte 0 is the oldest and maps to output lane N_OUT-1.
    always_comb begin
        out_tdata = '0;
        out_tkeep = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (j < int'(take)) begin
                out_tdata[(N_OUT-1-j)*8 +: 8] = data_q[j*8 +: 8];
                out_tkeep[N_OUT-1-j]          = 1'b1;
            end
        end
    end

    always_comb begin
        int pos;
        state_d = state_q;
        data_d  = data_q;
        pos     = int'(cnt_q);
        if (emit) begin
            data_d = data_q >> {take, 3'b000};
            pos    = pos - int'(take);
            if (out_tlast) begin
                state_d = PACK;
            end
        end
        // Appending happens after the shift so a same-cycle emit frees space first.
        if (accept) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (in_tkeep[i] && pos < BUF) begin
                    data_d[pos*8 +: 8] = in_tdata[i*8 +: 8];
                    pos = pos + 1;
                end
            end
            if (in_tlast) begin
                state_d = FLUSH;
            end
        end
        cnt_d = CW'(pos);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= PACK;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_gearbox_packing_tlast.sv
`timescale 1ns/1ps
// Scoreboard bench for gearbox_packing_tlast: byte-queue reference model with packet
// boundaries, plus a directed 10->4 width-conversion instance.
module tb_gearbox_packing_tlast;

    localparam int N_IN   = 10;
    localparam int N_OUT  = 10;
    localparam int BUF    = N_IN + N_OUT;
    localparam int FW     = $clog2(BUF + 1);
    localparam int N_OUT4 = 4;
    localparam int FW4    = $clog2(N_IN + N_OUT4 + 1);

    logic                 aclk;
    logic                 aresetn;
    logic [N_IN*8-1:0]    in_tdata;
    logic [N_IN-1:0]      in_tkeep;
    logic                 in_tlast;
    logic                 in_tvalid;
    logic                 in_tready;
    logic [N_OUT*8-1:0]   out_tdata;
    logic [N_OUT-1:0]     out_tkeep;
    logic                 out_tlast;
    logic                 out_tvalid;
    logic                 out_tready;
    logic [FW-1:0]        fill;

    logic [N_IN*8-1:0]    in_tdata4;
    logic [N_IN-1:0]      in_tkeep4;
    logic                 in_tlast4;
    logic                 in_tvalid4;
    logic                 in_tready4;
    logic [N_OUT4*8-1:0]  out_tdata4;
    logic [N_OUT4-1:0]    out_tkeep4;
    logic                 out_tlast4;
    logic                 out_tvalid4;
    logic                 out_tready4;
    logic [FW4-1:0]       fill4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending bytes in arrival order, and remaining byte counts of ended packets.
    logic [7:0] exp_bytes[$];
    int         ended[$];
    int         cur_len  = 0;
    int         pkts_in  = 0;
    int         pkts_out = 0;
    int         beats_out = 0;
    logic [N_OUT4*9:0] exp4[$];

    bit                        rand_rdy = 0;
    bit                        hold_valid = 0;
    logic [N_OUT*9+1:0]        held;
    logic [N_OUT*9:0]          last_beat = '0;

    int                        m_n;
    int                        m_rem;
    bit                        m_last;
    bit                        m_ended;
    logic [N_OUT*8-1:0]        m_data;
    logic [N_OUT-1:0]          m_keep;

    gearbox_packing_tlast #(.N_IN(N_IN), .N_OUT(N_OUT)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .fill(fill)
    );

    gearbox_packing_tlast #(.N_IN(N_IN), .N_OUT(N_OUT4)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .in_tdata(in_tdata4), .in_tkeep(in_tkeep4), .in_tlast(in_tlast4),
        .in_tvalid(in_tvalid4), .in_tready(in_tready4),
        .out_tdata(out_tdata4), .out_tkeep(out_tkeep4), .out_tlast(out_tlast4),
        .out_tvalid(out_tvalid4), .out_tready(out_tready4), .fill(fill4)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: runs at the negedge before the edge on which a handshake completes.
    always @(negedge aclk) begin
        if (!aresetn) begin
            pkts_in = pkts_in - ended.size();
            exp_bytes.delete();
            ended.delete();
            cur_len    = 0;
            hold_valid = 0;
        end else begin
            checkOutput("fill", fill, exp_bytes.size());
            checkOutput("in_tready", in_tready, (ended.size() == 0) && (exp_bytes.size() <= BUF - N_IN));
            checkOutput("out_tvalid", out_tvalid, (ended.size() > 0) || (exp_bytes.size() >= N_OUT));
            if (hold_valid) begin
                checkOutput("hold_stable", {out_tvalid, out_tdata, out_tkeep, out_tlast}, held);
            end
            hold_valid = out_tvalid && !out_tready;
            held       = {out_tvalid, out_tdata, out_tkeep, out_tlast};
            if (out_tvalid && out_tready) begin
                m_ended = (ended.size() > 0);
                if (m_ended) begin
                    m_rem  = ended[0];
                    m_n    = (m_rem < N_OUT) ? m_rem : N_OUT;
                    m_last = (m_rem <= N_OUT);
                end else begin
                    m_n     = N_OUT;
                    m_last  = 0;
                    cur_len = cur_len - N_OUT;
                end
                m_data = '0;
                m_keep = '0;
                for (int j = 0; j < m_n; j++) begin
                    if (exp_bytes.size() > 0) begin
                        m_data[(N_OUT-1-j)*8 +: 8] = exp_bytes.pop_front();
                        m_keep[N_OUT-1-j]          = 1'b1;
                    end
                end
                if (m_ended) begin
                    if (m_last) void'(ended.pop_front());
                    else ended[0] = ended[0] - m_n;
                end
                checkOutput("out_beat", {out_tdata, out_tkeep, out_tlast}, {m_data, m_keep, m_last});
                last_beat = {out_tdata, out_tkeep, out_tlast};
                beats_out++;
                if (out_tlast) pkts_out++;
            end
        end
    end

    // Input capture: records the beat accepted at the coming edge into the model.
    always @(negedge aclk) begin
        #1;
        if (aresetn && in_tvalid && in_tready) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (in_tkeep[i]) begin
                    exp_bytes.push_back(in_tdata[i*8 +: 8]);
                    cur_len++;
                end
            end
            if (in_tlast) begin
                ended.push_back(cur_len);
                cur_len = 0;
                pkts_in++;
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn && out_tvalid4 && out_tready4) begin
            if (exp4.size() == 0) checkOutput("dut4_extra_beat", 1, 0);
            else checkOutput("dut4_beat", {out_tdata4, out_tkeep4, out_tlast4}, exp4.pop_front());
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic applyStimulus(input logic [N_IN*8-1:0] d, input logic [N_IN-1:0] k, input logic l);
        bit took;
        int waited;
        in_tdata  = d;
        in_tkeep  = k;
        in_tlast  = l;
        in_tvalid = 1'b1;
        waited    = 0;
        do begin
            @(negedge aclk);
            took = in_tready;
            @(posedge aclk);
            #1;
            waited++;
        end while (!took && waited < 300);
        if (!took) checkOutput("accept_timeout", 1, 0);
        in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        out_tready = 1'b1;
        while ((exp_bytes.size() > 0 || ended.size() > 0) && w < 500) begin
            @(posedge aclk);
            #1;
            w++;
        end
        idle(1);
        if (exp_bytes.size() > 0 || ended.size() > 0) checkOutput("drain_timeout", 1, 0);
    endtask

    initial begin
        logic [95:0]       r;
        logic [N_IN*8-1:0] d1;
        logic [N_IN*8-1:0] d2;
        int                b0;
        bit                took;
        int                waited;

        aresetn    = 1'b0;
        in_tdata   = '0; in_tkeep  = '0; in_tlast  = 1'b0; in_tvalid  = 1'b0;
        in_tdata4  = '0; in_tkeep4 = '0; in_tlast4 = 1'b0; in_tvalid4 = 1'b0;
        out_tready = 1'b0;
        out_tready4 = 1'b1;

        repeat (2) @(posedge aclk);
        #1;
        checkOutput("reset_outputs", {in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, fill}, 0);
        aresetn = 1'b1;
        #1;
        checkOutput("ready_after_release", in_tready, 1);
        out_tready = 1'b1;

        $display("[TB] packing");
        applyStimulus("ABCDEFGHIJ", 10'b0001101011, 1'b0);
        applyStimulus("KLMONPQRST", 10'b1001001111, 1'b0);
        idle(2);
        checkOutput("t1_beat", last_beat, {"DEGIJKOQRS", 10'h3FF, 1'b0});
        checkOutput("t1_fill", fill, 1);

        $display("[TB] flush");
        applyStimulus("UVWXYabcde", 10'b0000000011, 1'b1);
        drain();
        checkOutput("t2_beat", last_beat, {"Tde", 56'h0, 10'b1110000000, 1'b1});

        $display("[TB] width conversion 10->4");
        exp4.push_back({"ABCD", 4'b1111, 1'b0});
        exp4.push_back({"EFGH", 4'b1111, 1'b0});
        exp4.push_back({"IJ", 16'h0, 4'b1100, 1'b1});
        in_tdata4  = "ABCDEFGHIJ";
        in_tkeep4  = '1;
        in_tlast4  = 1'b1;
        in_tvalid4 = 1'b1;
        waited = 0;
        do begin
            @(negedge aclk);
            took = in_tready4;
            @(posedge aclk);
            #1;
            waited++;
        end while (!took && waited < 50);
        in_tvalid4 = 1'b0;
        idle(6);
        checkOutput("dut4_all_beats", exp4.size(), 0);

        $display("[TB] backpressure");
        out_tready = 1'b0;
        applyStimulus("0123456789", '1, 1'b0);
        applyStimulus("abcdefghij", '1, 1'b0);
        in_tdata  = "klmnopqrst";
        in_tkeep  = '1;
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        checkOutput("t4_ready_low", in_tready, 0);
        out_tready = 1'b1;
        applyStimulus("klmnopqrst", '1, 1'b0);
        idle(5);
        checkOutput("t4_fill_empty", fill, 0);

        $display("[TB] null and empty cases");
        b0 = beats_out;
        applyStimulus("nullnullnu", '0, 1'b0);
        idle(3);
        checkOutput("t5_null_no_beat", beats_out - b0, 0);
        applyStimulus("nullnullnu", '0, 1'b1);
        drain();
        checkOutput("t5_empty_beat", last_beat, {80'h0, 10'h0, 1'b1});
        d1 = "ABCDEFGHIJ";
        d2 = "KLMNOPQRST";
        b0 = beats_out;
        applyStimulus(d1, '1, 1'b0);
        applyStimulus(d2, '1, 1'b1);
        drain();
        checkOutput("t5_boundary_beats", beats_out - b0, 2);
        checkOutput("t5_boundary_last", last_beat, {d2, 10'h3FF, 1'b1});

        $display("[TB] reset mid-packet");
        applyStimulus("zyxwvutsrq", 10'b1111111000, 1'b0);
        idle(1);
        checkOutput("t6_fill7", fill, 7);
        aresetn = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", {in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, fill}, 0);
        idle(2);
        aresetn = 1'b1;
        idle(1);
        applyStimulus("0123456789", 10'b1110000000, 1'b1);
        drain();
        checkOutput("t6_no_stale", last_beat, {"012", 56'h0, 10'b1110000000, 1'b1});

        $display("[TB] random soak");
        rand_rdy = 1;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            r = {$urandom, $urandom, $urandom};
            applyStimulus(r[N_IN*8-1:0], 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 7) == 0));
        end
        r = {$urandom, $urandom, $urandom};
        applyStimulus(r[N_IN*8-1:0], 10'($urandom_range(0, 1023)), 1'b1);
        rand_rdy = 0;
        drain();
        checkOutput("soak_packets", pkts_out, pkts_in);
        checkOutput("soak_empty", exp_bytes.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gearbox_packing_tlast.md
# gearbox_packing_tlast

AXI-Stream byte packer that removes null bytes (tkeep=0 lanes) from an `N_IN`-byte input stream and repacks the surviving bytes, in order, into dense `N_OUT`-byte output words. It is the parametrised successor of the fixed-width packer:

- Input and output widths are independent, so the block also works as a byte-level up/down-sizer.
- `in_tlast` is honoured: on packet end the block flushes a partial final word marked by `out_tkeep`/`out_tlast`.

It sits between a sparse-keep producer (header strippers, field extractors) and a dense-stream consumer.

## Interface
- `N_IN`, default 10: input lanes (bytes), ≥1
- `N_OUT`, default 10: output lanes (bytes), ≥1
- `BUF`, derived = `N_IN+N_OUT`: internal byte capacity
- `aclk` in 1: clock; one clock, all logic on rising edge
- `aresetn` in 1: reset, asynchronous, active-low
- `in_tdata` in `N_IN*8`: input bytes, lane i = `[i*8+:8]`
- `in_tkeep` in `N_IN`: 1 = lane i carries a valid byte
- `in_tlast` in 1: last beat of packet
- `in_tvalid` in 1 / `in_tready` out 1: input handshake
- `out_tdata` out `N_OUT*8`: packed bytes
- `out_tkeep` out `N_OUT`: valid lanes of output beat
- `out_tlast` out 1: last beat of packet
- `out_tvalid` out 1 / `out_tready` in 1: output handshake
- `fill` out `$clog2(BUF+1)`: bytes currently buffered

## Operation
- **Byte order is MSB-lane first.** Within an input beat, lane `N_IN-1` is the oldest byte and lane 0 the youngest. On output, the oldest byte goes to lane `N_OUT-1`.
- **Input accept** when `in_tvalid & in_tready`. All lanes with keep=1 are appended to the buffer in order; `cnt += popcount(in_tkeep)`.
- **`in_tready`** = `!flush_pending && cnt <= BUF-N_IN`.
  - It depends on registered state only, with no combinational path from `out_tready`.
  - Any accepted beat is guaranteed to fit.
- **`out_tvalid`** = `cnt >= N_OUT || flush_pending`.
- **`out_tlast`** = `flush_pending && cnt <= N_OUT`.
- **`out_tkeep`**:
  - All ones when `cnt >= N_OUT`.
  - Otherwise the top `cnt` lanes are set, i.e. lanes `N_OUT-1` down to `N_OUT-cnt`.
  - Unused data lanes are driven to 0.
- **Output emit** when `out_tvalid & out_tready`:
  - `min(cnt, N_OUT)` oldest bytes are removed.
  - If `out_tlast` is set, `flush_pending` clears.
- **Simultaneous accept and emit in one cycle:** `cnt_next = cnt - emitted + popcount(keep)`. Bytes are appended after the shift.
- **States:** PACK (`flush_pending=0`) and FLUSH (`flush_pending=1`).
  - PACK→FLUSH on accept with `in_tlast=1`. Bytes of that beat are included.
  - FLUSH→PACK on emit of the `out_tlast` beat.
- **Null beat:** keep=0 with tlast=0 is accepted and has no effect. keep=0 with tlast=1 enters FLUSH.
- **Empty flush:** if FLUSH is entered with `cnt==0`, exactly one beat is emitted with `out_tkeep=0` and `out_tlast=1`.
- **Exact multiple:** if `cnt==N_OUT` in FLUSH, that full word carries `out_tlast=1` and no extra beat follows.

## Timing
- **Reset:** while `aresetn=0`, all outputs are 0: `in_tready`, `out_tvalid`, `out_tdata`, `out_tkeep`, `out_tlast`, `fill`. Internal `cnt=0` and `flush_pending=0`.
  - Reset assertion mid-packet discards all buffered bytes immediately and asynchronously.
  - `in_tready=1` on the first cycle after release.
- **Latency:** a byte accepted at edge k is visible on `out_tdata` after edge k, provided it completes a word or a flush.
- **Throughput:** with `N_IN=N_OUT`, full keep and `out_tready=1`, one beat per cycle is sustained.
- **AXI rule:** while `out_tvalid & !out_tready`, `out_tdata`, `out_tkeep` and `out_tlast` are held stable. `out_tvalid` never drops without a handshake.
- **FLUSH:** `in_tready=0` from the cycle after the tlast accept until the cycle after the `out_tlast` handshake.

## Test plan
1. **Packing, defaults, `out_tready=1`:**
   - Stimulus: "ABCDEFGHIJ" keep 0001101011, then "KLMONPQRST" keep 1001001111.
   - Response: one beat "DEGIJKOQRS", `out_tkeep`=all ones, `out_tlast=0`, `fill=1`.
2. **Flush, continuing from 1:**
   - Stimulus: "UVWXYabcde" keep 0000000011, tlast=1.
   - Response: beat with "Tde" in lanes 9..7, lanes 6..0 = 0, `out_tkeep`=1110000000, `out_tlast=1`.
   - `in_tready` is low until that handshake completes.
3. **Width conversion, `N_IN=10`, `N_OUT=4`:**
   - Stimulus: "ABCDEFGHIJ" keep all ones, tlast=1.
   - Response: beats "ABCD"/1111, "EFGH"/1111, then "IJ" in lanes 3..2 with keep 1100; only the third beat has `out_tlast=1`.
4. **Backpressure:**
   - Stimulus: full-keep beats streamed with `out_tready=0` for 5 cycles.
   - Response: `in_tready` falls once `cnt>BUF-N_IN`; the output beat is held bit-stable; after release, the byte sequence matches the scoreboard with no loss or duplication.
5. **Null and empty cases:**
   - keep=0, tlast=0 → accepted, nothing emitted.
   - keep=0, tlast=1 with `cnt=0` → exactly one beat with `out_tkeep=0`, `out_tlast=1`.
   - 20 bytes followed by tlast on the word boundary → two full beats, `out_tlast` on the second only.
6. **Reset and random soak:**
   - Reset mid-operation: `aresetn` driven low with `fill=7` → outputs 0 within the same cycle; after release no stale bytes appear.
   - Random soak: 500 random keep/tlast/pause beats with random `out_tready` → 0 scoreboard errors, and every input packet boundary reproduced by `out_tlast`.
